// File: rtl/sram_operand_fetch_if.sv
// Command, SRAM read port and output byte stream of the operand fetch unit.
// SRAM_OPERAND_FETCH_CHECKSUM_EN adds the running Checksum output.
interface sram_operand_fetch_if #(
    parameter int A_WIDTH   = 15,
    parameter int D_WIDTH   = 8,
    parameter int CNT_WIDTH = 16
);
    logic                 Start;
    logic [A_WIDTH-1:0]   Base_Addr;
    logic [CNT_WIDTH-1:0] Count;
    logic                 Sram_En;
    logic                 Sram_RW;
    logic [A_WIDTH-1:0]   Sram_Addr;
    logic [D_WIDTH-1:0]   Sram_Data;
    logic [D_WIDTH-1:0]   Out_Data;
    logic                 Out_Valid;
    logic                 Out_Ready;
    logic                 Busy;
    logic                 Done;
`ifdef SRAM_OPERAND_FETCH_CHECKSUM_EN
    logic [D_WIDTH-1:0]   Checksum;

    modport master (
        input  Start, Base_Addr, Count, Sram_Data, Out_Ready,
        output Sram_En, Sram_RW, Sram_Addr, Out_Data, Out_Valid, Busy, Done, Checksum
    );
    modport slave (
        output Start, Base_Addr, Count, Sram_Data, Out_Ready,
        input  Sram_En, Sram_RW, Sram_Addr, Out_Data, Out_Valid, Busy, Done, Checksum
    );
`else
    modport master (
        input  Start, Base_Addr, Count, Sram_Data, Out_Ready,
        output Sram_En, Sram_RW, Sram_Addr, Out_Data, Out_Valid, Busy, Done
    );
    modport slave (
        output Start, Base_Addr, Count, Sram_Data, Out_Ready,
        input  Sram_En, Sram_RW, Sram_Addr, Out_Data, Out_Valid, Busy, Done
    );
`endif
endinterface

// File: rtl/sram_operand_fetch.sv
// Sequential SRAM reader feeding a small FIFO that drains over a valid/ready stream.
// Optional feature macro: SRAM_OPERAND_FETCH_CHECKSUM_EN (byte-sum of delivered data).
module sram_operand_fetch #(
    parameter int A_WIDTH    = 15,
    parameter int D_WIDTH    = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input logic                  Clk,
    input logic                  Rst,
    sram_operand_fetch_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t               state_q, state_d;
    logic [A_WIDTH-1:0]   addr_q, addr_d;
    logic [CNT_WIDTH-1:0] issue_left_q, issue_left_d;
    logic [CNT_WIDTH-1:0] deliver_left_q, deliver_left_d;
    logic                 rd_pending_q;
    logic [D_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        fifo_count_q;
    logic [CW:0]          credit;
    logic                 start_acc, issue, push, pop, fifo_nonempty;
    logic [D_WIDTH-1:0]   head;

    // Reads in flight count against FIFO space so a returning byte always has room.
    assign credit        = {1'b0, fifo_count_q} + (CW+1)'(rd_pending_q);
    assign fifo_nonempty = (fifo_count_q != '0);
    assign start_acc     = (state_q == IDLE) && bus.Start;
    assign issue         = (state_q == FETCH) && (issue_left_q != '0) &&
                           (credit < (CW+1)'(FIFO_DEPTH));
    assign push          = rd_pending_q;
    assign pop           = fifo_nonempty && bus.Out_Ready;
    assign head          = fifo_nonempty ? fifo_mem[rd_ptr_q] : '0;

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        issue_left_d   = issue_left_q;
        deliver_left_d = deliver_left_q;
        if (pop) begin
            deliver_left_d = deliver_left_q - CNT_WIDTH'(1);
        end
        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    addr_d         = bus.Base_Addr;
                    issue_left_d   = bus.Count;
                    deliver_left_d = bus.Count;
                    state_d        = (bus.Count == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (issue) begin
                    addr_d       = addr_q + A_WIDTH'(1);
                    issue_left_d = issue_left_q - CNT_WIDTH'(1);
                    if (issue_left_q == CNT_WIDTH'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (deliver_left_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            issue_left_q   <= '0;
            deliver_left_q <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            issue_left_q   <= issue_left_d;
            deliver_left_q <= deliver_left_d;
        end
    end

    // Read data arrives one cycle after the enable; rd_pending marks that cycle.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rd_pending_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            rd_pending_q <= issue;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count_q <= fifo_count_q + CW'(1);
                2'b01:   fifo_count_q <= fifo_count_q - CW'(1);
                default: fifo_count_q <= fifo_count_q;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= bus.Sram_Data;
        end
    end

`ifdef SRAM_OPERAND_FETCH_CHECKSUM_EN
    logic [D_WIDTH-1:0] checksum_q;

    always_ff @(posedge Clk) begin
        if (Rst || start_acc) begin
            checksum_q <= '0;
        end else if (pop) begin
            checksum_q <= checksum_q + head;
        end
    end

    assign bus.Checksum = checksum_q;
`endif

    assign bus.Sram_En   = issue;
    assign bus.Sram_RW   = 1'b0;
    assign bus.Sram_Addr = addr_q;
    assign bus.Out_Data  = head;
    assign bus.Out_Valid = fifo_nonempty;
    assign bus.Busy      = (state_q == FETCH) || (state_q == DRAIN);
    assign bus.Done      = (state_q == DONE);
endmodule

// File: tb/tb_sram_operand_fetch.sv
// Directed bench for sram_operand_fetch with a registered-read SRAM model.
module tb_sram_operand_fetch;
    localparam int AW = 15;
    localparam int DW = 8;
    localparam int CW = 16;
    localparam int FD = 4;

    logic Clk = 1'b0;
    logic Rst;
    always #5 Clk = ~Clk;

    sram_operand_fetch_if #(.A_WIDTH(AW), .D_WIDTH(DW), .CNT_WIDTH(CW)) bus();

    sram_operand_fetch #(.A_WIDTH(AW), .D_WIDTH(DW), .FIFO_DEPTH(FD), .CNT_WIDTH(CW)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    logic [7:0] mem [0:32767];
    always @(posedge Clk) begin
        if (bus.Sram_En) bus.Sram_Data <= mem[bus.Sram_Addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [7:0]  got_q [$];
    logic [14:0] addr_log [$];
    int first_vld, last_xfer, done_cnt, done_cyc, en_cnt, en_pre_rel, stall_bad;
    logic busy_c1, busy_after, done_after;
    logic [7:0] held_first;
    logic [7:0] csum_at_done;

    // Issue Start at the current (post-negedge) time and watch up to max_cyc cycles.
    task automatic run_xfer(input logic [14:0] base, input logic [15:0] cnt,
                            input int stall, input int restart_cyc, input int max_cyc);
        logic [7:0] held;
        bit held_vld;
        held_vld = 0; held = '0; held_first = '0;
        got_q.delete(); addr_log.delete();
        first_vld = -1; last_xfer = -1; done_cnt = 0; done_cyc = -1;
        en_cnt = 0; en_pre_rel = 0; stall_bad = 0;
        busy_c1 = 1'bx; busy_after = 1'bx; done_after = 1'bx; csum_at_done = '0;
        bus.Start = 1'b1; bus.Base_Addr = base; bus.Count = cnt;
        bus.Out_Ready = (stall == 0);
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            @(negedge Clk);
            bus.Start = (cyc == restart_cyc);
            if (cyc == restart_cyc) begin
                bus.Base_Addr = 15'h0123;
                bus.Count     = 16'd3;
            end
            bus.Out_Ready = (cyc > stall);
            if (cyc == 1) busy_c1 = bus.Busy;
            if (done_cyc > 0 && cyc == done_cyc + 1) begin
                busy_after = bus.Busy;
                done_after = bus.Done;
                break;
            end
            if (bus.Sram_En) begin
                en_cnt++;
                addr_log.push_back(bus.Sram_Addr);
                if (cyc <= stall) en_pre_rel++;
            end
            if (bus.Out_Valid && first_vld < 0) first_vld = cyc;
            if (bus.Out_Valid && bus.Out_Ready) begin
                got_q.push_back(bus.Out_Data);
                last_xfer = cyc;
            end
            if (bus.Out_Valid && !bus.Out_Ready) begin
                if (held_vld && bus.Out_Data !== held) stall_bad++;
                if (!held_vld) held_first = bus.Out_Data;
                held = bus.Out_Data;
                held_vld = 1;
            end
            if (bus.Done) begin
                done_cnt++;
                done_cyc = cyc;
`ifdef SRAM_OPERAND_FETCH_CHECKSUM_EN
                csum_at_done = bus.Checksum;
`endif
            end
        end
        bus.Start = 1'b0;
        bus.Out_Ready = 1'b1;
    endtask

    task automatic check_bytes(input string tag, input logic [7:0] exp [$]);
        check_eq({tag, "_len"}, got_q.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            check_eq($sformatf("%s_b%0d", tag, i), (i < got_q.size()) ? got_q[i] : 8'hxx, exp[i]);
        end
    endtask

    initial begin
        logic [7:0] exp_b [$];
        int bad;
        for (int a = 0; a < 32768; a++) mem[a] = 8'h00;
        mem[15'h0010] = 8'h11; mem[15'h0011] = 8'h22; mem[15'h0012] = 8'h33; mem[15'h0013] = 8'h44;
        mem[15'h7FFE] = 8'hA1; mem[15'h7FFF] = 8'hA2; mem[15'h0000] = 8'hA3; mem[15'h0001] = 8'hA4;
        for (int i = 0; i < 10; i++) mem[15'h0100 + i] = 8'h50 + 8'(i);
        for (int i = 0; i < 5; i++)  mem[15'h0300 + i] = 8'h60 + 8'(i);
        mem[15'h0200] = 8'hF0; mem[15'h0201] = 8'h20; mem[15'h0202] = 8'h05;

        Rst = 1'b1; bus.Start = 1'b0; bus.Base_Addr = '0; bus.Count = '0; bus.Out_Ready = 1'b0;
        repeat (3) @(negedge Clk);
        check_eq("rst_busy", bus.Busy, 0);
        check_eq("rst_done", bus.Done, 0);
        check_eq("rst_valid", bus.Out_Valid, 0);
        check_eq("rst_data", bus.Out_Data, 0);
        check_eq("rst_addr", bus.Sram_Addr, 0);
        check_eq("rst_en", bus.Sram_En, 0);
        check_eq("rst_rw", bus.Sram_RW, 0);
        Rst = 1'b0;
        @(negedge Clk);

        // Basic transfer: latency, back-to-back bytes, single Done.
        run_xfer(15'h0010, 16'd4, 0, 0, 40);
        check_eq("s1_busy_c1", busy_c1, 1);
        check_eq("s1_first_valid", first_vld, 3);
        check_eq("s1_consecutive", last_xfer - first_vld, 3);
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        check_bytes("s1", exp_b);
        check_eq("s1_done_cnt", done_cnt, 1);
        check_eq("s1_done_cyc", done_cyc, 8);
        check_eq("s1_busy_after", busy_after, 0);
        check_eq("s1_done_after", done_after, 0);

        // Address wrap at the top of the SRAM.
        run_xfer(15'h7FFE, 16'd4, 0, 0, 40);
        exp_b = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        check_bytes("s2", exp_b);
        check_eq("s2_en_cnt", en_cnt, 4);
        check_eq("s2_addr0", (addr_log.size() > 0) ? addr_log[0] : 15'h0, 15'h7FFE);
        check_eq("s2_addr1", (addr_log.size() > 1) ? addr_log[1] : 15'h0, 15'h7FFF);
        check_eq("s2_addr2", (addr_log.size() > 2) ? addr_log[2] : 15'h7FFF, 15'h0000);
        check_eq("s2_addr3", (addr_log.size() > 3) ? addr_log[3] : 15'h0, 15'h0001);

        // Backpressure: 8 stalled cycles with Count=10.
        run_xfer(15'h0100, 16'd10, 8, 0, 80);
        check_eq("s3_issue_in_stall", en_pre_rel, FD);
        check_eq("s3_stall_stable", stall_bad, 0);
        check_eq("s3_held_byte", held_first, 8'h50);
        exp_b = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h58, 8'h59};
        check_bytes("s3", exp_b);
        check_eq("s3_done_cnt", done_cnt, 1);

        // Zero-length command.
        run_xfer(15'h0040, 16'd0, 0, 0, 20);
        check_eq("s4_en_cnt", en_cnt, 0);
        check_eq("s4_done_cyc", done_cyc, 1);
        check_eq("s4_no_valid", first_vld < 0, 1);
        check_eq("s4_done_cnt", done_cnt, 1);

        // A second Start while busy must be ignored.
        run_xfer(15'h0300, 16'd5, 0, 2, 60);
        exp_b = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h64};
        check_bytes("s4b", exp_b);
        check_eq("s4b_en_cnt", en_cnt, 5);
        check_eq("s4b_done_cnt", done_cnt, 1);
        check_eq("s4b_busy_after", busy_after, 0);

        // Reset in the middle of a transfer.
        bus.Start = 1'b1; bus.Base_Addr = 15'h0100; bus.Count = 16'd8;
        @(negedge Clk);
        bus.Start = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        check_eq("s5_busy", bus.Busy, 0);
        check_eq("s5_done", bus.Done, 0);
        check_eq("s5_valid", bus.Out_Valid, 0);
        check_eq("s5_data", bus.Out_Data, 0);
        check_eq("s5_addr", bus.Sram_Addr, 0);
        check_eq("s5_en", bus.Sram_En, 0);
        Rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            if (bus.Done || bus.Out_Valid || bus.Sram_En || bus.Busy) bad++;
        end
        check_eq("s5_quiet_after_rst", bad, 0);
        run_xfer(15'h0010, 16'd4, 0, 0, 40);
        check_eq("s5_first_valid", first_vld, 3);
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        check_bytes("s5", exp_b);
        check_eq("s5_done_cnt", done_cnt, 1);

`ifdef SRAM_OPERAND_FETCH_CHECKSUM_EN
        run_xfer(15'h0200, 16'd3, 0, 0, 40);
        check_eq("cs_value", csum_at_done, 8'h15);
        @(negedge Clk);
        check_eq("cs_hold", bus.Checksum, 8'h15);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
